// File: rtl/fp32_cmul_sequencer.sv
// fp32_cmul_sequencer
//   Accepts one complex operand pair (a, w) per transaction. It issues the four
//   real products ar*wr, ai*wi, ar*wi, ai*wr in that order to one shared,
//   pipelined FP32 multiplier. It then presents the four products as one bundle.
//   The multiplier has no valid signal, so a tag pipe of depth MUL_LATENCY
//   travels alongside it. Each tag names the product register that the result
//   arriving in that cycle belongs to.
//
// Ports
//   clk, rst                  clock, synchronous active-high reset
//   in_valid/in_ready         operand pair handshake
//   a_re,a_im,w_re,w_im,rm    operands (IEEE-754 single) and rounding mode
//   mul_x,mul_y,mul_rm        registered operands to the multiplier (0 outside ISSUE)
//   mul_product,mul_flags     multiplier result, MUL_LATENCY cycles after operands
//   out_valid/out_ready       product bundle handshake
//   p_rr,p_ii,p_ri,p_ir       ar*wr, ai*wi, ar*wi, ai*wr
//   out_flags                 OR of the four products' flags
//   dbg_state                 current FSM state (IDLE=0, ISSUE=1, WAIT=2, HOLD=3)
//   flags_clr,sticky_flags    only with FP32_CMUL_STICKY_FLAGS_EN: sticky flag
//                             accumulator over accepted bundles, clearable
//
// Handshake: a transfer happens on a rising clk edge where valid && ready.
// valid never depends on ready. Once out_valid is high, it stays high until
// the transfer, and the data stays stable during that time.
//
// Optional feature macro: FP32_CMUL_STICKY_FLAGS_EN
module fp32_cmul_sequencer #(
    parameter int MUL_LATENCY = 3,
    parameter int FLAG_W      = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       a_re,
    input  logic [31:0]       a_im,
    input  logic [31:0]       w_re,
    input  logic [31:0]       w_im,
    input  logic [2:0]        rm,
    output logic [31:0]       mul_x,
    output logic [31:0]       mul_y,
    output logic [2:0]        mul_rm,
    input  logic [31:0]       mul_product,
    input  logic [FLAG_W-1:0] mul_flags,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       p_rr,
    output logic [31:0]       p_ii,
    output logic [31:0]       p_ri,
    output logic [31:0]       p_ir,
    output logic [FLAG_W-1:0] out_flags,
`ifdef FP32_CMUL_STICKY_FLAGS_EN
    input  logic              flags_clr,
    output logic [FLAG_W-1:0] sticky_flags,
`endif
    output logic [1:0]        dbg_state
);

    typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, WAIT = 2'd2, HOLD = 2'd3} state_t;

    state_t                        state;
    logic [1:0]                    cnt;
    logic [31:0]                   ar_q, ai_q, wr_q, wi_q;
    logic [2:0]                    rm_q;
    logic [MUL_LATENCY-1:0]        tag_vld;
    logic [MUL_LATENCY-1:0][1:0]   tag_idx;
    logic [31:0]                   nxt_x, nxt_y;
    logic                          tag_hit;
    logic [1:0]                    tag_out;

    assign dbg_state = state;
    assign tag_hit   = tag_vld[MUL_LATENCY-1];
    assign tag_out   = tag_idx[MUL_LATENCY-1];

    // Operands for the product after the current one. Product 0 is loaded
    // straight from the inputs at accept time, so that mul_x is valid in the
    // first ISSUE cycle.
    always_comb begin
        nxt_x = 32'h0;
        nxt_y = 32'h0;
        case (cnt)
            2'd0:    begin nxt_x = ai_q; nxt_y = wi_q; end
            2'd1:    begin nxt_x = ar_q; nxt_y = wi_q; end
            2'd2:    begin nxt_x = ai_q; nxt_y = wr_q; end
            default: begin nxt_x = 32'h0; nxt_y = 32'h0; end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= 2'd0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            mul_x     <= 32'h0;
            mul_y     <= 32'h0;
            mul_rm    <= 3'd0;
            ar_q      <= 32'h0;
            ai_q      <= 32'h0;
            wr_q      <= 32'h0;
            wi_q      <= 32'h0;
            rm_q      <= 3'd0;
            p_rr      <= 32'h0;
            p_ii      <= 32'h0;
            p_ri      <= 32'h0;
            p_ir      <= 32'h0;
            out_flags <= '0;
            tag_vld   <= '0;
            tag_idx   <= '0;
`ifdef FP32_CMUL_STICKY_FLAGS_EN
            sticky_flags <= '0;
`endif
        end else begin
            // The tag pushed while operands sit on mul_x leaves the last stage
            // in the same cycle that the matching product is on mul_product.
            for (int i = MUL_LATENCY - 1; i > 0; i--) begin
                tag_vld[i] <= tag_vld[i-1];
                tag_idx[i] <= tag_idx[i-1];
            end
            tag_vld[0] <= (state == ISSUE);
            tag_idx[0] <= cnt;

            if (tag_hit) begin
                case (tag_out)
                    2'd0:    p_rr <= mul_product;
                    2'd1:    p_ii <= mul_product;
                    2'd2:    p_ri <= mul_product;
                    default: p_ir <= mul_product;
                endcase
                out_flags <= out_flags | mul_flags;
            end

`ifdef FP32_CMUL_STICKY_FLAGS_EN
            // A clear in the same cycle as a handshake keeps that bundle's flags.
            sticky_flags <= (flags_clr ? '0 : sticky_flags)
                          | ((state == HOLD && out_ready) ? out_flags : '0);
`endif

            case (state)
                IDLE: begin
                    if (in_valid) begin
                        ar_q      <= a_re;
                        ai_q      <= a_im;
                        wr_q      <= w_re;
                        wi_q      <= w_im;
                        rm_q      <= rm;
                        mul_x     <= a_re;
                        mul_y     <= w_re;
                        mul_rm    <= rm;
                        cnt       <= 2'd0;
                        in_ready  <= 1'b0;
                        out_flags <= '0;
                        state     <= ISSUE;
                    end
                end
                ISSUE: begin
                    cnt <= cnt + 2'd1;
                    if (cnt == 2'd3) begin
                        mul_x  <= 32'h0;
                        mul_y  <= 32'h0;
                        mul_rm <= 3'd0;
                        state  <= WAIT;
                    end else begin
                        mul_x  <= nxt_x;
                        mul_y  <= nxt_y;
                        mul_rm <= rm_q;
                    end
                end
                WAIT: begin
                    if (tag_hit && tag_out == 2'd3) begin
                        out_valid <= 1'b1;
                        state     <= HOLD;
                    end
                end
                default: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
            endcase
        end
    end

endmodule
